// File: rtl/switch_debounce_events_if.sv
// Switch-side signal bundle for switch_debounce_events: raw input plus debounced level and event pulses.
// master = consumer/driver of the raw switch, slave = the debouncer.
interface switch_debounce_events_if;
   logic i_Switch;
   logic o_Switch;
   logic o_Press;
   logic o_Release;
   logic o_Long_Press;

   modport master (
      output i_Switch,
      input  o_Switch,
      input  o_Press,
      input  o_Release,
      input  o_Long_Press
   );

   modport slave (
      input  i_Switch,
      output o_Switch,
      output o_Press,
      output o_Release,
      output o_Long_Press
   );
endinterface

// File: rtl/switch_debounce_events.sv
// Push-button conditioner: debounced level plus registered press/release/long-press pulses.
// Define SWITCH_SYNC_EN to put a 2-flop synchronizer ahead of the sample register.
module switch_debounce_events #(
   parameter int unsigned DEBOUNCE_LIMIT   = 250000,
   parameter int unsigned LONG_PRESS_LIMIT = 25000000
) (
   input logic                     i_Clk,
   input logic                     i_Rst_L,
   switch_debounce_events_if.slave sw
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_LIMIT);
   localparam int unsigned HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              sample_q;
   logic              level_q, level_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;
   logic              commit;

`ifdef SWITCH_SYNC_EN
   logic [1:0] sync_q;

   // Two metastability flops, then the sample register.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sync_q   <= 2'b00;
         sample_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], sw.i_Switch};
         sample_q <= sync_q[1];
      end
   end
`else
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sample_q <= 1'b0;
      end else begin
         sample_q <= sw.i_Switch;
      end
   end
`endif

   // State and registered outputs.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q   <= ST_IDLE;
         level_q   <= 1'b0;
         db_cnt_q  <= '0;
         hold_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         db_cnt_q  <= db_cnt_d;
         hold_q    <= hold_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      db_cnt_d  = '0;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      commit    = 1'b0;

      // Any agreeing sample restarts the run of differing samples.
      if (sample_q != level_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_LIMIT - 1)) begin
            commit  = 1'b1;
            level_d = sample_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (commit) begin
               state_d = ST_HELD;
               hold_d  = HOLD_W'(1);
               press_d = 1'b1;
            end
         end
         ST_HELD: begin
            // Release wins over a long-press landing on the same edge.
            if (commit) begin
               state_d   = ST_IDLE;
               hold_d    = '0;
               release_d = 1'b1;
            end else if (hold_q == HOLD_W'(LONG_PRESS_LIMIT)) begin
               state_d = ST_LONG;
               long_d  = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         ST_LONG: begin
            if (commit) begin
               state_d   = ST_IDLE;
               hold_d    = '0;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = '0;
         end
      endcase
   end

   assign sw.o_Switch     = level_q;
   assign sw.o_Press      = press_q;
   assign sw.o_Release    = release_q;
   assign sw.o_Long_Press = long_q;

endmodule
